// File: rtl/conv_layer_scheduler_if.sv
// Handshake and layer-geometry bundle between the layer scheduler and the
// convolution datapath / weight loader / PS.
interface conv_layer_scheduler_if;
   logic        start;
   logic        wgt_req;
   logic        wgt_done;
   logic        conv_start;
   logic        conv_done;
   logic [8:0]  ifm_width;
   logic [10:0] ifm_channel;
   logic [10:0] ofm_channel;
   logic        is_conv_3;
   logic        pool_en;
   logic [10:0] grp_base;
   logic [4:0]  grp_cnt;
   logic        buf_sel;
   logic [3:0]  layer_idx;
   logic        busy;
   logic        done;

   modport master (
      input  start, wgt_done, conv_done,
      output wgt_req, conv_start, ifm_width, ifm_channel, ofm_channel,
             is_conv_3, pool_en, grp_base, grp_cnt, buf_sel, layer_idx,
             busy, done
   );

   modport slave (
      output start, wgt_done, conv_done,
      input  wgt_req, conv_start, ifm_width, ifm_channel, ofm_channel,
             is_conv_3, pool_en, grp_base, grp_cnt, buf_sel, layer_idx,
             busy, done
   );
endinterface

// File: rtl/conv_layer_scheduler.sv
// YOLOv2-tiny layer sequencer: walks the fixed layer table, runs one engine
// pass per group of OFM_PAR output channels and flips the ping-pong buffers.
module conv_layer_scheduler #(
   parameter int NUM_LAYERS = 9,
   parameter int OFM_PAR    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   conv_layer_scheduler_if.master   bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_CFG, S_WREQ, S_RUN, S_WAIT, S_NEXTG, S_SWAP, S_DONE
   } state_t;

   typedef struct packed {
      logic [8:0]  width;
      logic [10:0] ich;
      logic [10:0] och;
      logic        k3;
      logic        pool;
   } layer_cfg_t;

   localparam logic [11:0] PAR12 = 12'(OFM_PAR);
   localparam logic [10:0] PAR11 = 11'(OFM_PAR);
   localparam logic [4:0]  PAR5  = 5'(OFM_PAR);
   localparam logic [3:0]  LAST  = 4'(NUM_LAYERS - 1);

   function automatic layer_cfg_t layer_lut(input logic [3:0] idx);
      case (idx)
         4'd0:    return '{9'd416, 11'd3,    11'd16,   1'b1, 1'b1};
         4'd1:    return '{9'd208, 11'd16,   11'd32,   1'b1, 1'b1};
         4'd2:    return '{9'd104, 11'd32,   11'd64,   1'b1, 1'b1};
         4'd3:    return '{9'd52,  11'd64,   11'd128,  1'b1, 1'b1};
         4'd4:    return '{9'd26,  11'd128,  11'd256,  1'b1, 1'b1};
         4'd5:    return '{9'd13,  11'd256,  11'd512,  1'b1, 1'b0};
         4'd6:    return '{9'd13,  11'd512,  11'd1024, 1'b1, 1'b0};
         4'd7:    return '{9'd13,  11'd1024, 11'd1024, 1'b1, 1'b0};
         4'd8:    return '{9'd13,  11'd1024, 11'd125,  1'b0, 1'b0};
         default: return '0;
      endcase
   endfunction

   // Remaining channels are formed in 12 bits so a short last group cannot wrap.
   function automatic logic [4:0] grp_cnt_f(input logic [10:0] och, input logic [10:0] base);
      logic [11:0] rem;
      rem = {1'b0, och} - {1'b0, base};
      return (rem >= PAR12) ? PAR5 : rem[4:0];
   endfunction

   state_t      state_q;
   logic        wgt_req_q, conv_start_q, busy_q, done_q, buf_sel_q;
   logic [3:0]  layer_idx_q;
   logic [10:0] grp_base_q;
   logic [4:0]  grp_cnt_q;
   logic [8:0]  ifm_width_q;
   logic [10:0] ifm_channel_q, ofm_channel_q;
   logic        is_conv_3_q, pool_en_q;

   layer_cfg_t  cfg_d;
   logic [10:0] grp_base_d;
   logic        more_grp_d;

   always_comb begin
      cfg_d      = layer_lut(layer_idx_q);
      grp_base_d = grp_base_q + PAR11;
      more_grp_d = (({1'b0, grp_base_q} + PAR12) < {1'b0, ofm_channel_q});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         wgt_req_q     <= 1'b0;
         conv_start_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         buf_sel_q     <= 1'b0;
         layer_idx_q   <= '0;
         grp_base_q    <= '0;
         grp_cnt_q     <= '0;
         ifm_width_q   <= '0;
         ifm_channel_q <= '0;
         ofm_channel_q <= '0;
         is_conv_3_q   <= 1'b0;
         pool_en_q     <= 1'b0;
      end else begin
         conv_start_q <= 1'b0;
         done_q       <= 1'b0;
         case (state_q)
            S_IDLE: if (bus.start) begin
               layer_idx_q <= '0;
               grp_base_q  <= '0;
               buf_sel_q   <= 1'b0;
               busy_q      <= 1'b1;
               state_q     <= S_CFG;
            end
            S_CFG: begin
               ifm_width_q   <= cfg_d.width;
               ifm_channel_q <= cfg_d.ich;
               ofm_channel_q <= cfg_d.och;
               is_conv_3_q   <= cfg_d.k3;
               pool_en_q     <= cfg_d.pool;
               grp_cnt_q     <= grp_cnt_f(cfg_d.och, 11'd0);
               wgt_req_q     <= 1'b1;
               state_q       <= S_WREQ;
            end
            S_WREQ: if (bus.wgt_done) begin
               wgt_req_q    <= 1'b0;
               conv_start_q <= 1'b1;
               state_q      <= S_RUN;
            end
            S_RUN:  state_q <= S_WAIT;
            S_WAIT: if (bus.conv_done) state_q <= S_NEXTG;
            S_NEXTG: begin
               if (more_grp_d) begin
                  grp_base_q <= grp_base_d;
                  grp_cnt_q  <= grp_cnt_f(ofm_channel_q, grp_base_d);
                  wgt_req_q  <= 1'b1;
                  state_q    <= S_WREQ;
               end else begin
                  state_q <= S_SWAP;
               end
            end
            S_SWAP: begin
               buf_sel_q  <= ~buf_sel_q;
               grp_base_q <= '0;
               if (layer_idx_q == LAST) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  layer_idx_q <= layer_idx_q + 4'd1;
                  state_q     <= S_CFG;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.wgt_req     = wgt_req_q;
   assign bus.conv_start  = conv_start_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.buf_sel     = buf_sel_q;
   assign bus.layer_idx   = layer_idx_q;
   assign bus.grp_base    = grp_base_q;
   assign bus.grp_cnt     = grp_cnt_q;
   assign bus.ifm_width   = ifm_width_q;
   assign bus.ifm_channel = ifm_channel_q;
   assign bus.ofm_channel = ofm_channel_q;
   assign bus.is_conv_3   = is_conv_3_q;
   assign bus.pool_en     = pool_en_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Scoreboard bench for conv_layer_scheduler: full network, single-layer build,
// stalled handshakes, spurious pulses and asynchronous reset mid-run.
module tb_conv_layer_scheduler;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv_layer_scheduler_if b9();
   conv_layer_scheduler_if b1();

   conv_layer_scheduler #(.NUM_LAYERS(9), .OFM_PAR(16)) dut9 (.clk(clk), .rst_n(rst_n), .bus(b9.master));
   conv_layer_scheduler #(.NUM_LAYERS(1), .OFM_PAR(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // Hand-written layer table: width, ifm_ch, ofm_ch, k3, pool
   int tw[9]  = '{416, 208, 104, 52, 26, 13, 13, 13, 13};
   int tic[9] = '{3, 16, 32, 64, 128, 256, 512, 1024, 1024};
   int toc[9] = '{16, 32, 64, 128, 256, 512, 1024, 1024, 125};
   int tk3[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
   int tpl[9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};

   function automatic logic [63:0] rec(input int kind, input int layer, input int base, input int cnt,
                                       input int bsel, input int w, input int ic, input int oc,
                                       input int k3, input int pool);
      return {9'd0, 1'(kind), 4'(layer), 11'(base), 5'(cnt), 1'(bsel), 9'(w), 11'(ic), 11'(oc),
              1'(k3), 1'(pool)};
   endfunction

   function automatic logic [63:0] snap9(input int kind);
      return {9'd0, 1'(kind), b9.layer_idx, b9.grp_base, b9.grp_cnt, b9.buf_sel, b9.ifm_width,
              b9.ifm_channel, b9.ofm_channel, b9.is_conv_3, b9.pool_en};
   endfunction

   logic [63:0] sb[$];

   task automatic push_network();
      for (int l = 0; l < 9; l++)
         for (int b = 0; b < toc[l]; b += 16)
            sb.push_back(rec(0, l, b, (toc[l] - b < 16) ? toc[l] - b : 16, l % 2,
                             tw[l], tic[l], toc[l], tk3[l], tpl[l]));
      sb.push_back(rec(1, 8, 0, 13, 1, 13, 1024, 125, 0, 0));
   endtask

   // Monitor: pops the scoreboard on every engine start and on the done pulse
   int   n_conv = 0, n_tog = 0, cyc = 0, last_cs_cyc = 0, last_cs_layer = -1;
   bit   fast = 0, done_seen = 0;
   logic prev_buf = 1'b0;

   initial forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
         if (b9.conv_start) begin
            n_conv++;
            if (sb.size() == 0) chk("sb_underflow_conv", 64'd1, 64'd0);
            else chk("sb_group", snap9(0), sb.pop_front());
            if (fast && last_cs_layer == int'(b9.layer_idx))
               chk("grp_period", 64'(cyc - last_cs_cyc), 64'd4);
            last_cs_cyc   = cyc;
            last_cs_layer = int'(b9.layer_idx);
         end
         if (b9.done) begin
            done_seen = 1;
            if (sb.size() == 0) chk("sb_underflow_done", 64'd1, 64'd0);
            else chk("sb_done", snap9(1), sb.pop_front());
         end
         if (b9.buf_sel !== prev_buf) n_tog++;
         prev_buf = b9.buf_sel;
      end else begin
         prev_buf = 1'b0;
      end
   end

   // Responder: weight loader and engine models with programmable latency
   int   wgt_dly = 0, conv_dly = 0, wcnt = 0, ccnt = 0;
   bit   wpend = 0, cpend = 0, spur_cd = 0;
   logic wd, cd;

   initial begin
      b9.wgt_done  = 1'b0;
      b9.conv_done = 1'b0;
      forever begin
         @(negedge clk);
         wd = 1'b0;
         cd = 1'b0;
         if (!rst_n) begin
            wpend = 0;
            cpend = 0;
         end else begin
            if (b9.wgt_req && !wpend) begin
               wpend = 1;
               wcnt  = wgt_dly;
            end
            if (wpend) begin
               if (wcnt == 0) begin
                  wd    = 1'b1;
                  wpend = 0;
               end else wcnt--;
            end
            if (b9.conv_start) begin
               cpend = 1;
               ccnt  = conv_dly;
            end else if (cpend) begin
               if (ccnt == 0) begin
                  cd    = 1'b1;
                  cpend = 0;
               end else ccnt--;
            end
         end
         if (spur_cd) begin
            cd      = 1'b1;
            spur_cd = 0;
         end
         b9.wgt_done  = wd;
         b9.conv_done = cd;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] snap;
      logic [33:0] cfg1;
      bit   bad, cs_prev;
      int   k, n1, d1;

      b9.start = 1'b0;
      b1.start = 1'b0;
      b1.wgt_done = 1'b0;
      b1.conv_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset9_ctl", 64'({b9.wgt_req, b9.conv_start, b9.busy, b9.done}), 64'd0);
      chk("reset9_cfg", snap9(0), 64'd0);
      chk("reset1_ctl", 64'({b1.wgt_req, b1.conv_start, b1.busy, b1.done, b1.buf_sel, b1.layer_idx}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single-layer build, immediate acknowledges
      b1.start = 1'b1;
      @(negedge clk);
      b1.start = 1'b0;
      n1 = 0; d1 = 0; cs_prev = 0; cfg1 = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         b1.conv_done = cs_prev;
         cs_prev      = b1.conv_start;
         b1.wgt_done  = b1.wgt_req;
         if (b1.conv_start) begin
            n1++;
            cfg1 = {b1.ifm_width, b1.ifm_channel, b1.ofm_channel, b1.is_conv_3, b1.pool_en};
         end
         if (b1.done) d1++;
      end
      b1.conv_done = 1'b0;
      b1.wgt_done  = 1'b0;
      chk("l1_conv_starts", 64'(n1), 64'd1);
      chk("l1_cfg", 64'(cfg1), 64'({9'd416, 11'd3, 11'd16, 1'b1, 1'b1}));
      chk("l1_done_pulses", 64'(d1), 64'd1);
      chk("l1_final", 64'({b1.buf_sel, b1.busy, b1.layer_idx}), 64'({1'b1, 1'b0, 4'd0}));

      // Stalled handshakes with spurious conv_done and start
      wgt_dly = 50; conv_dly = 200; fast = 0; n_conv = 0;
      push_network();
      b9.start = 1'b1;
      @(negedge clk);
      b9.start = 1'b0;
      k = 0;
      while (!b9.wgt_req && k < 20) begin @(negedge clk); k++; end
      chk("stall_wreq_seen", 64'(b9.wgt_req), 64'd1);
      snap = snap9(0); bad = 0;
      for (int i = 1; i < 50; i++) begin
         @(negedge clk);
         if (!(b9.wgt_req === 1'b1 && b9.conv_start === 1'b0 && snap9(0) === snap)) bad = 1;
         if (i == 10) spur_cd = 1;
      end
      chk("stall_wreq_hold", 64'(bad), 64'd0);
      k = 0;
      while (!b9.conv_start && k < 20) begin @(negedge clk); k++; end
      chk("stall_cs_seen", 64'(b9.conv_start), 64'd1);
      snap = snap9(0); bad = 0;
      for (int i = 1; i < 200; i++) begin
         @(negedge clk);
         if (!(b9.conv_start === 1'b0 && b9.wgt_req === 1'b0 && b9.busy === 1'b1 && snap9(0) === snap)) bad = 1;
         if (i == 20) b9.start = 1'b1;
         if (i == 21) b9.start = 1'b0;
      end
      chk("stall_wait_hold", 64'(bad), 64'd0);
      chk("no_rerun", 64'(n_conv), 64'd1);

      // Run into layer 3 and reset asynchronously while the engine is busy
      wgt_dly = 0; conv_dly = 20;
      k = 0;
      while (!(b9.conv_start && b9.layer_idx == 4'd3) && k < 3000) begin @(negedge clk); k++; end
      #1;
      chk("reach_L3", 64'({b9.conv_start, b9.layer_idx, b9.buf_sel}), 64'({1'b1, 4'd3, 1'b1}));
      chk("groups_before_L3", 64'(n_conv), 64'd8);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", 64'({b9.busy, b9.wgt_req, b9.conv_start, b9.layer_idx, b9.buf_sel, b9.grp_base}), 64'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Full network, immediate acknowledges
      fast = 1; wgt_dly = 0; conv_dly = 0;
      n_conv = 0; n_tog = 0; done_seen = 0; last_cs_layer = -1;
      push_network();
      b9.start = 1'b1;
      @(negedge clk);
      b9.start = 1'b0;
      chk("cfg_cycle", 64'({b9.busy, b9.wgt_req, b9.layer_idx}), 64'({1'b1, 1'b0, 4'd0}));
      @(negedge clk);
      chk("wreq_latency", 64'({b9.wgt_req, b9.ifm_width, b9.grp_cnt}), 64'({1'b1, 9'd416, 5'd16}));
      k = 0;
      while (!done_seen && k < 3000) begin @(negedge clk); k++; end
      #1;
      chk("done_seen", 64'(done_seen), 64'd1);
      chk("total_conv_starts", 64'(n_conv), 64'd199);
      chk("buf_toggles", 64'(n_tog), 64'd9);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      @(negedge clk);
      chk("busy_drop", 64'({b9.busy, b9.done, b9.wgt_req}), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_layer_scheduler.md
# conv_layer_scheduler

Top-level sequencer for the YOLOv2-tiny convolution pipeline. It walks a fixed 9-entry layer table and presents each layer's geometry to the convolution datapath and its IFM remain/row controller (`ifm_width`, `ifm_channel`, `ofm_channel`, `is_conv_3`). For every group of OFM_PAR output channels it requests the weights, starts the engine and waits for completion. It swaps the ping-pong feature-map buffers between layers and reports progress to the PS.

## Interface
Parameters:
- NUM_LAYERS, 9, number of table entries executed; legal range 1..9.
- OFM_PAR, 16, output channels computed per engine pass; power of two, at most 16.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle run request; honoured only in IDLE.
- wgt_req  output  1  weight-load request; level, held until wgt_done.
- wgt_done  input  1  one-cycle acknowledge from the weight loader.
- conv_start  output  1  one-cycle engine start pulse.
- conv_done  input  1  one-cycle engine completion pulse.
- ifm_width  output  9  current layer IFM width.
- ifm_channel  output  11  current layer IFM channel count.
- ofm_channel  output  11  current layer OFM channel count.
- is_conv_3  output  1  1 = 3x3 kernel, 0 = 1x1 kernel.
- pool_en  output  1  max-pool stage enabled for this layer.
- grp_base  output  11  first OFM channel of the current group.
- grp_cnt  output  5  channels in the current group (1..OFM_PAR).
- buf_sel  output  1  ping-pong select: 0 = read buffer A / write buffer B.
- layer_idx  output  4  current layer index.
- busy  output  1  high from CFG until DONE inclusive.
- done  output  1  one-cycle pulse at end of network.

## Operation
- Layer table (width, ifm_ch, ofm_ch, k3, pool):
  - L0: 416, 3, 16, 1, 1
  - L1: 208, 16, 32, 1, 1
  - L2: 104, 32, 64, 1, 1
  - L3: 52, 64, 128, 1, 1
  - L4: 26, 128, 256, 1, 1
  - L5: 13, 256, 512, 1, 0
  - L6: 13, 512, 1024, 1, 0
  - L7: 13, 1024, 1024, 1, 0
  - L8: 13, 1024, 125, 0, 0
- FSM states: IDLE, CFG, WREQ, RUN, WAIT, NEXTG, SWAP, DONE.
- IDLE → CFG on `start`. `layer_idx`=0, `grp_base`=0, `buf_sel`=0.
- CFG: register the table entry onto the config outputs, compute `grp_cnt`, then go to WREQ. Config outputs are stable from the cycle after CFG until the next CFG.
- WREQ: `wgt_req`=1. On `wgt_done`, go to RUN.
- RUN: `conv_start`=1 for exactly this cycle, then go to WAIT.
- WAIT: on `conv_done`, go to NEXTG.
- NEXTG:
  - If `grp_base + OFM_PAR < ofm_channel`: `grp_base += OFM_PAR`, recompute `grp_cnt`, go to WREQ.
  - Otherwise go to SWAP.
- SWAP: toggle `buf_sel` and set `grp_base`=0.
  - If `layer_idx == NUM_LAYERS-1`, go to DONE.
  - Otherwise increment `layer_idx` and go to CFG.
- DONE: pulse `done`, then go to IDLE. `busy` drops in the IDLE cycle.
- `grp_cnt` = min(OFM_PAR, `ofm_channel` − `grp_base`), computed in 12-bit arithmetic so there is no underflow. For L8 with OFM_PAR=16: 7 groups of 16, then 13.
- `start` outside IDLE is ignored. `wgt_done` outside WREQ and `conv_done` outside WAIT are ignored and not stored.
- `wgt_done` and `conv_done` arriving in the same cycle: only the one matching the current state is acted on.
- Reset, asynchronous and possibly mid-run: FSM→IDLE. All outputs return to the reset values below immediately; no pending handshake survives.

## Timing
- Reset values: `wgt_req`=0, `conv_start`=0, `busy`=0, `done`=0, `buf_sel`=0, `layer_idx`=0, `grp_base`=0, `grp_cnt`=0, all config outputs 0.
- `start`@T → CFG@T+1 → WREQ@T+2 with `wgt_req` high, config outputs valid.
- `wgt_done`@W → `conv_start` high @W+1.
- `conv_done`@C → NEXTG@C+1 → next `wgt_req`@C+2 (same layer) or SWAP@C+2.
- Layer turnaround from SWAP: CFG@C+3, `wgt_req`@C+4.
- `wgt_done` in the same cycle `wgt_req` rises is legal.
- Fixed scheduler overhead per group: 3 cycles.

## Test plan
- Reset, then NUM_LAYERS=1, OFM_PAR=16, immediate acknowledges → exactly 1 `conv_start`; `ifm_width`=416, `ifm_channel`=3, `is_conv_3`=1, `pool_en`=1; `done` pulse; `buf_sel` ends at 1.
- Full network with OFM_PAR=16 → total `conv_start` count 1+2+4+8+16+32+64+64+8 = 199. L8 `grp_cnt` sequence is 16×7 then 13, with final `grp_base`=112.
- Stall `wgt_done` 50 cycles and `conv_done` 200 cycles → `wgt_req` held steady, no extra `conv_start`, config outputs constant throughout.
- Spurious `conv_done` during WREQ, and `start` pulsed during WAIT → no state change, no second run.
- Assert `rst_n` low mid-L3 WAIT → `busy`, `wgt_req`, `layer_idx` and `buf_sel` clear asynchronously. The next `start` restarts at L0.
- `wgt_done` coincident with `wgt_req` rise, `conv_done` one cycle after `conv_start` → per-group period is exactly 4 cycles; `done` asserted after 9 `buf_sel` toggles.
